// File: rtl/morse_key_timer_if.sv
// Symbol handshake between the Morse symbol source and the key timer.
// The source drives the symbol and unit length; the timer returns ready.
interface morse_key_timer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             sym_valid;
    logic [2:0]       sym_code;
    logic             sym_ready;
    logic [CNT_W-1:0] unit_cycles;

    modport master (
        output sym_valid,
        output sym_code,
        output unit_cycles,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_code,
        input  unit_cycles,
        output sym_ready
    );
endinterface

// File: rtl/morse_key_timer.sv
// Morse timing back-end: turns accepted dot/dash/space symbols into a keyed output whose
// on/off durations are unit multiples, with the unit length latched at each accept.
module morse_key_timer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DASH_UNITS = 3,
    parameter int unsigned GAP_UNITS  = 1,
    parameter int unsigned CHAR_UNITS = 3,
    parameter int unsigned WORD_UNITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    morse_key_timer_if.slave        sym_if,
    output logic                    key_out,
    output logic                    busy,
    output logic                    sym_done,
    output logic                    sym_err
);
    localparam int unsigned MaxDG    = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int unsigned MaxCW    = (CHAR_UNITS > WORD_UNITS) ? CHAR_UNITS : WORD_UNITS;
    localparam int unsigned MaxUnits = (MaxDG > MaxCW) ? MaxDG : MaxCW;
    localparam int unsigned UW       = $clog2(MaxUnits + 1);

    localparam logic [UW-1:0] DotLast  = '0;
    localparam logic [UW-1:0] DashLast = UW'(DASH_UNITS - 1);
    localparam logic [UW-1:0] GapLast  = UW'(GAP_UNITS - 1);
    localparam logic [UW-1:0] CharLast = UW'(CHAR_UNITS - 1);
    localparam logic [UW-1:0] WordLast = UW'(WORD_UNITS - 1);

    typedef enum logic [1:0] {StIdle, StMark, StGap, StSpace} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] u_last_q, u_last_d;
    logic [UW-1:0]    unit_q, unit_d;
    logic [UW-1:0]    units_last_q, units_last_d;
    logic             key_q, busy_q, done_q, err_q;
    logic             done_d, err_d;
    logic             accept;

    assign sym_if.sym_ready = (state_q == StIdle) && !rst;
    assign accept           = sym_if.sym_valid && sym_if.sym_ready;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        u_last_d     = u_last_q;
        unit_d       = unit_q;
        units_last_d = units_last_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    presc_d  = '0;
                    unit_d   = '0;
                    // A zero unit length behaves as one clock per unit.
                    u_last_d = (sym_if.unit_cycles == '0) ? '0
                                                          : sym_if.unit_cycles - CNT_W'(1);
                    case (sym_if.sym_code)
                        3'b001: begin state_d = StMark;  units_last_d = DotLast;  end
                        3'b010: begin state_d = StMark;  units_last_d = DashLast; end
                        3'b011: begin state_d = StSpace; units_last_d = CharLast; end
                        3'b100: begin state_d = StSpace; units_last_d = WordLast; end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StMark, StGap, StSpace: begin
                if (presc_q == u_last_q) begin
                    presc_d = '0;
                    if (unit_q == units_last_q) begin
                        unit_d = '0;
                        if (state_q == StMark) begin
                            state_d      = StGap;
                            units_last_d = GapLast;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            u_last_q     <= '0;
            unit_q       <= '0;
            units_last_q <= '0;
            key_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            u_last_q     <= u_last_d;
            unit_q       <= unit_d;
            units_last_q <= units_last_d;
            key_q        <= (state_d == StMark);
            busy_q       <= (state_d != StIdle);
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign key_out  = key_q;
    assign busy     = busy_q;
    assign sym_done = done_q;
    assign sym_err  = err_q;
endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: a per-cycle expected-output queue built from symbol durations,
// checked every cycle, plus directed scenarios with hand-computed durations.
module tb_morse_key_timer;
    localparam int unsigned CNT_W = 16;
    localparam int DASH = 3;
    localparam int GAP  = 1;
    localparam int CHAR = 3;
    localparam int WORD = 7;

    typedef struct packed {
        logic key;
        logic busy;
        logic ready;
        logic done;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_out, busy, sym_done, sym_err;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    morse_key_timer_if #(.CNT_W(CNT_W)) sif ();

    morse_key_timer #(
        .CNT_W      (CNT_W),
        .DASH_UNITS (DASH),
        .GAP_UNITS  (GAP),
        .CHAR_UNITS (CHAR),
        .WORD_UNITS (WORD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_if   (sif),
        .key_out  (key_out),
        .busy     (busy),
        .sym_done (sym_done),
        .sym_err  (sym_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_run(input int n, input exp_t e);
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Model: on every accepted symbol, queue the exact output values for each following cycle.
    always @(posedge clk) begin
        logic model_ready;
        int   u;
        if (rst) begin
            q.delete();
        end else begin
            model_ready = (q.size() == 0) ? 1'b1 : q[0].ready;
            if (q.size() != 0) void'(q.pop_front());
            if (sif.sym_valid && model_ready) begin
                u = (sif.unit_cycles == 0) ? 1 : int'(sif.unit_cycles);
                case (sif.sym_code)
                    3'd1, 3'd2: begin
                        push_run(((sif.sym_code == 3'd1) ? 1 : DASH) * u, '{1, 1, 0, 0, 0});
                        push_run(GAP * u, '{0, 1, 0, 0, 0});
                        push_run(1, '{0, 0, 1, 1, 0});
                    end
                    3'd3, 3'd4: begin
                        push_run(((sif.sym_code == 3'd3) ? CHAR : WORD) * u, '{0, 1, 0, 0, 0});
                        push_run(1, '{0, 0, 1, 1, 0});
                    end
                    default: push_run(1, '{0, 0, 1, 0, 1});
                endcase
            end
        end
    end

    always @(negedge clk) begin
        exp_t exp_v;
        exp_t act_v;
        if (rst)                 exp_v = '{0, 0, 0, 0, 0};
        else if (q.size() != 0) exp_v = q[0];
        else                     exp_v = '{0, 0, 1, 0, 0};
        act_v = '{key_out, busy, sif.sym_ready, sym_done, sym_err};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t {key,busy,ready,done,err} actual %b required %b",
                     $time, act_v, exp_v);
        end
    end

    // Called at a negedge; returns at the negedge of the cycle where busy is low again.
    task automatic send(input logic [2:0] code, input logic [CNT_W-1:0] u, input int mid_cyc,
                        input logic [CNT_W-1:0] u_mid, output int high, output int low,
                        output int done_at, output int err);
        int guard = 0;
        high = 0; low = 0; done_at = -1; err = 0;
        sif.sym_valid   = 1'b1;
        sif.sym_code    = code;
        sif.unit_cycles = u;
        while (!sif.sym_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1 sif.sym_valid = 1'b0;
        for (int n = 1; n < 5000; n++) begin
            @(negedge clk);
            if (n == mid_cyc) sif.unit_cycles = u_mid;
            if (key_out) high++;
            else if (busy) low++;
            if (!busy) begin
                if (sym_done) done_at = n;
                err = int'(sym_err);
                break;
            end
            if (n == 4999) chk("symbol_timeout", 0, 1);
        end
    endtask

    initial begin
        int h, l, d, e;
        sif.sym_valid   = 1'b1;
        sif.sym_code    = 3'd1;
        sif.unit_cycles = 16'd4;
        repeat (3) @(negedge clk);
        chk("rst_key", int'(key_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(sif.sym_ready), 0);
        #1 rst = 1'b0;
        #1;
        chk("release_ready", int'(sif.sym_ready), 1);
        chk("release_busy", int'(busy), 0);

        send(3'd1, 16'd4, 0, 16'd0, h, l, d, e);
        chk("dot4_high", h, 4); chk("dot4_low", l, 4); chk("dot4_done", d, 9);
        chk("dot4_ready", int'(sif.sym_ready), 1);

        send(3'd2, 16'd2, 0, 16'd0, h, l, d, e);
        chk("dash2_high", h, 6); chk("dash2_low", l, 2); chk("dash2_done", d, 9);
        send(3'd2, 16'd2, 0, 16'd0, h, l, d, e);
        chk("dash2b_high", h, 6); chk("dash2b_done", d, 9);
        send(3'd3, 16'd2, 0, 16'd0, h, l, d, e);
        chk("char2_high", h, 0); chk("char2_low", l, 6); chk("char2_done", d, 7);
        send(3'd4, 16'd2, 0, 16'd0, h, l, d, e);
        chk("word2_low", l, 14); chk("word2_done", d, 15);

        send(3'd2, 16'd3, 2, 16'd10, h, l, d, e);
        chk("dash3_high", h, 9); chk("dash3_low", l, 3); chk("dash3_done", d, 13);
        send(3'd1, 16'd10, 0, 16'd0, h, l, d, e);
        chk("dot10_high", h, 10); chk("dot10_low", l, 10);

        send(3'd0, 16'd4, 0, 16'd0, h, l, d, e);
        chk("ill0_err", e, 1); chk("ill0_done", d, -1); chk("ill0_high", h, 0);
        send(3'd7, 16'd4, 0, 16'd0, h, l, d, e);
        chk("ill7_err", e, 1); chk("ill7_done", d, -1);
        send(3'd1, 16'd4, 0, 16'd0, h, l, d, e);
        chk("dot_after_err", h, 4); chk("dot_after_err_done", d, 9);

        // Abort a dash with reset in its second mark cycle.
        sif.sym_valid = 1'b1; sif.sym_code = 3'd2; sif.unit_cycles = 16'd3;
        @(posedge clk);
        #1 sif.sym_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_key_before", int'(key_out), 1);
        #1 rst = 1'b1;
        #1 chk("abort_key_now", int'(key_out), 0);
        @(negedge clk);
        chk("abort_done", int'(sym_done), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", int'(sym_done), 0);
        send(3'd1, 16'd0, 0, 16'd0, h, l, d, e);
        chk("dot0_high", h, 1); chk("dot0_low", l, 1); chk("dot0_done", d, 3);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] code;
            int r = int'($urandom_range(0, 19));
            if (r < 6)       code = 3'd1;
            else if (r < 11) code = 3'd2;
            else if (r < 14) code = 3'd3;
            else if (r < 17) code = 3'd4;
            else begin
                int k = int'($urandom_range(0, 3));
                code = (k == 0) ? 3'd0 : 3'(k + 4);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(code, 16'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                 16'($urandom_range(0, 5)), h, l, d, e);
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog expired");
    end
endmodule
